// File: rtl/game_sequencer_pkg.sv
// Shared state encodings and default parameter values for the game sequencer.
package game_pkg;

    localparam int unsigned CLK_DIV_DEF    = 65000000;
    localparam int unsigned DEB_CYCLES_DEF = 650000;
    localparam int unsigned LIVES_DEF      = 3;
    localparam int unsigned HOLD_S_DEF     = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_PAUSED    = 3'd2,
        ST_LIFE_LOST = 3'd3,
        ST_OVER      = 3'd4,
        ST_WIN       = 3'd5
    } state_t;

endpackage

// File: rtl/game_sequencer_btn_conditioner.sv
// Raw button -> 2-flop synchronizer -> debouncer -> one-cycle rising-edge pulse.
module btn_conditioner
    import game_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk_65M,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic          armed;
    logic [CW-1:0] cnt;

    // Until a stable low has been seen, a button held through reset cannot
    // debounce high, so it yields no pulse until released and pressed again.
    always_ff @(posedge clk_65M or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            level <= 1'b0;
            armed <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            pulse <= 1'b0;
            if (!armed) begin
                if (sync[1])
                    cnt <= '0;
                else if (cnt == CNT_MAX) begin
                    armed <= 1'b1;
                    cnt   <= '0;
                end else
                    cnt <= cnt + 1'b1;
            end else if (sync[1] != level) begin
                if (cnt == CNT_MAX) begin
                    level <= sync[1];
                    pulse <= sync[1];
                    cnt   <= '0;
                end else
                    cnt <= cnt + 1'b1;
            end else
                cnt <= '0;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game control sequencer: 1 s prescaler, button conditioning and the game FSM.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned LIVES      = LIVES_DEF,
    parameter int unsigned HOLD_S     = HOLD_S_DEF
) (
    input  logic       clk_65M,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       mode_ext,
    input  logic       collision,
    input  logic       goal,
    input  logic [9:0] time_left,
    output logic       tick_1s,
    output logic       game_start,
    output logic       game_on,
    output logic       pause,
    output logic       endf,
    output logic       timef,
    output logic       win,
    output logic [1:0] lives,
    output logic [2:0] state
);

    localparam int unsigned PW = $clog2(CLK_DIV + 1);
    localparam int unsigned HW = $clog2(HOLD_S + 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_S - 1);
    localparam logic [1:0]    LIVES_V  = 2'(LIVES);

    logic          start_p, pause_p;
    logic [PW-1:0] pre_cnt;
    logic [HW-1:0] hold_cnt;
    state_t        st, st_n;
    logic [1:0]    lives_n;
    logic          timef_n;

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_start (
        .clk_65M(clk_65M), .reset(reset), .btn(btn_start), .pulse(start_p)
    );
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_pause (
        .clk_65M(clk_65M), .reset(reset), .btn(btn_pause), .pulse(pause_p)
    );

    assign tick_1s = (pre_cnt == PRE_MAX);
    assign state   = st;

    always_ff @(posedge clk_65M or posedge reset) begin
        if (reset)        pre_cnt <= '0;
        else if (tick_1s) pre_cnt <= '0;
        else              pre_cnt <= pre_cnt + 1'b1;
    end

    // Held at zero outside LIFE_LOST, so every entry starts a fresh freeze.
    always_ff @(posedge clk_65M or posedge reset) begin
        if (reset)                   hold_cnt <= '0;
        else if (st != ST_LIFE_LOST) hold_cnt <= '0;
        else if (tick_1s)            hold_cnt <= hold_cnt + 1'b1;
    end

    always_comb begin
        st_n    = st;
        lives_n = lives;
        timef_n = timef;
        case (st)
            ST_IDLE: if (start_p) begin
                st_n    = ST_RUN;
                lives_n = LIVES_V;
                timef_n = mode_ext;
            end
            ST_RUN: begin
                if (time_left == '0)
                    st_n = ST_OVER;
                else if (goal)
                    st_n = ST_WIN;
                else if (collision) begin
                    if (lives <= 2'd1) begin
                        st_n    = ST_OVER;
                        lives_n = 2'd0;
                    end else begin
                        st_n    = ST_LIFE_LOST;
                        lives_n = lives - 2'd1;
                    end
                end else if (pause_p)
                    st_n = ST_PAUSED;
            end
            ST_PAUSED:    if (pause_p) st_n = ST_RUN;
            ST_LIFE_LOST: if (tick_1s && hold_cnt == HOLD_MAX) st_n = ST_RUN;
            ST_OVER, ST_WIN: if (start_p) begin
                st_n    = ST_IDLE;
                lives_n = 2'd0;
                timef_n = 1'b0;
            end
            default: begin
                st_n    = ST_IDLE;
                lives_n = 2'd0;
                timef_n = 1'b0;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they line up with state.
    always_ff @(posedge clk_65M or posedge reset) begin
        if (reset) begin
            st         <= ST_IDLE;
            lives      <= 2'd0;
            timef      <= 1'b0;
            game_start <= 1'b0;
            game_on    <= 1'b0;
            pause      <= 1'b0;
            endf       <= 1'b0;
            win        <= 1'b0;
        end else begin
            st         <= st_n;
            lives      <= lives_n;
            timef      <= timef_n;
            game_start <= (st_n != ST_IDLE);
            game_on    <= (st_n == ST_RUN);
            pause      <= (st_n == ST_PAUSED) || (st_n == ST_LIFE_LOST);
            endf       <= (st_n == ST_OVER) || (st_n == ST_WIN);
            win        <= (st_n == ST_WIN);
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized self-checking bench for game_sequencer against an abstract game model.
module tb_game_sequencer;

    logic       clk_65M = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0, btn_pause = 1'b0, mode_ext = 1'b0;
    logic       collision = 1'b0, goal = 1'b0;
    logic [9:0] time_left = 10'd100;
    logic       tick_1s, game_start, game_on, pause, endf, timef, win;
    logic [1:0] lives;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    // Abstract model: 0 idle, 1 run, 2 paused, 3 life lost, 4 over, 5 win.
    int m_state = 0;
    int m_lives = 0;
    int m_timef = 0;

    game_sequencer #(.CLK_DIV(10), .DEB_CYCLES(4), .LIVES(3), .HOLD_S(2)) dut (
        .clk_65M(clk_65M), .reset(reset), .btn_start(btn_start), .btn_pause(btn_pause),
        .mode_ext(mode_ext), .collision(collision), .goal(goal), .time_left(time_left),
        .tick_1s(tick_1s), .game_start(game_start), .game_on(game_on), .pause(pause),
        .endf(endf), .timef(timef), .win(win), .lives(lives), .state(state)
    );

    always #5 clk_65M = ~clk_65M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, state, m_state);
        chk({tag, ".lives"}, lives, m_lives);
        chk({tag, ".timef"}, timef, m_timef);
        chk({tag, ".game_start"}, game_start, m_state != 0);
        chk({tag, ".game_on"}, game_on, m_state == 1);
        chk({tag, ".pause"}, pause, m_state == 2 || m_state == 3);
        chk({tag, ".endf"}, endf, m_state == 4 || m_state == 5);
        chk({tag, ".win"}, win, m_state == 5);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_65M);
    endtask

    // Hold a button for n cycles, release, and let the debouncer settle.
    task automatic press(input bit is_pause, input int n);
        if (is_pause) btn_pause = 1'b1; else btn_start = 1'b1;
        cyc(n);
        btn_pause = 1'b0;
        btn_start = 1'b0;
        cyc(12);
    endtask

    task automatic m_start(input int mode);
        if (m_state == 0) begin
            m_state = 1; m_lives = 3; m_timef = mode;
        end else if (m_state == 4 || m_state == 5) begin
            m_state = 0; m_lives = 0; m_timef = 0;
        end
    endtask

    task automatic m_pause();
        if (m_state == 1) m_state = 2;
        else if (m_state == 2) m_state = 1;
    endtask

    task automatic m_event(input bit col, input bit gl, input bit tz);
        if (m_state != 1) return;
        if (tz) m_state = 4;
        else if (gl) m_state = 5;
        else if (col) begin
            m_lives = m_lives - 1;
            m_state = (m_lives == 0) ? 4 : 3;
        end
    endtask

    // One-cycle game inputs, then a check; a lost life is also checked after the freeze.
    task automatic fire(input string tag, input bit col, input bit gl, input bit tz);
        collision = col;
        goal = gl;
        if (tz) time_left = 10'd0;
        cyc(1);
        collision = 1'b0;
        goal = 1'b0;
        time_left = 10'($urandom_range(1, 1023));
        m_event(col, gl, tz);
        check_all(tag);
        if (m_state == 3) begin
            cyc(25);
            m_state = 1;
            check_all({tag, ".resume"});
        end
    endtask

    task automatic do_start(input string tag, input int mode);
        mode_ext = mode[0];
        press(1'b0, 8);
        m_start(mode);
        mode_ext = ~mode_ext;
        check_all(tag);
    endtask

    task automatic do_pause(input string tag, input int n);
        press(1'b1, n);
        if (n >= 4) m_pause();
        check_all(tag);
    endtask

    int cyc_no = 0;
    int last_tick = -1;
    always @(negedge clk_65M) begin
        if (reset) last_tick = -1;
        else if (tick_1s) begin
            if (last_tick >= 0) chk("tick_period", cyc_no - last_tick, 10);
            last_tick = cyc_no;
        end
        cyc_no++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc(3);
        check_all("reset");
        chk("reset.tick", tick_1s, 0);
        reset = 1'b0;
        cyc(10);

        do_start("start_ext", 1);
        do_pause("glitch", 3);
        do_pause("pause_on", 6);
        fire("pause_tzero", 1'b0, 1'b0, 1'b1);
        fire("pause_col", 1'b1, 1'b0, 1'b0);
        do_start("pause_start", 0);
        do_pause("pause_off", 6);
        fire("col1", 1'b1, 1'b0, 1'b0);
        fire("col2", 1'b1, 1'b0, 1'b0);
        fire("col3", 1'b1, 1'b0, 1'b0);
        do_start("over_restart", 0);
        do_start("start_std", 0);
        fire("goal_and_tzero", 1'b0, 1'b1, 1'b1);
        do_start("over_idle", 1);
        do_start("start2", 1);
        fire("goal_only", 1'b0, 1'b1, 1'b0);
        do_start("win_idle", 0);
        do_start("start3", 0);
        do_pause("pause_before_rst", 6);

        btn_start = 1'b1;
        cyc(2);
        reset = 1'b1;
        cyc(3);
        m_state = 0; m_lives = 0; m_timef = 0;
        reset = 1'b0;
        cyc(20);
        check_all("rst_held");
        btn_start = 1'b0;
        cyc(12);
        check_all("rst_release");
        do_start("rst_fresh", 1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: do_start("rnd_start", int'($urandom_range(0, 1)));
                1: do_pause("rnd_pause", 6);
                2: fire("rnd_col", 1'b1, 1'b0, 1'b0);
                3: fire("rnd_goal", 1'b0, 1'b1, 1'b0);
                4: fire("rnd_tzero", 1'b0, 1'b0, 1'b1);
                default: fire("rnd_mix", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 65000000, clk_65M cycles per 1 s tick.
REQ-002 Parameter DEB_CYCLES, default 650000, stable cycles needed to accept a button level (10 ms).
REQ-003 Parameter LIVES, default 3, lives per game (1..3).
REQ-004 Parameter HOLD_S, default 2, freeze length in ticks after a life is lost.
REQ-005 clk_65M  in  1  system clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 btn_start  in  1  raw start/restart button (asynchronous).
REQ-008 btn_pause  in  1  raw pause toggle button (asynchronous).
REQ-009 mode_ext  in  1  extended-time mode select, sampled at game start.
REQ-010 collision  in  1  single-cycle pulse, player hit an obstacle.
REQ-011 goal  in  1  single-cycle pulse, player reached the goal.
REQ-012 time_left  in  10  remaining seconds reported by the countdown timer.
REQ-013 tick_1s  out  1  one-cycle strobe every CLK_DIV cycles.
REQ-014 game_start, game_on, pause, endf, timef  out  1 each  timer/game control.
REQ-015 win  out  1  high in WIN state.
REQ-016 lives  out  2  lives remaining.
REQ-017 state  out  3  current FSM state encoding.

Function
REQ-018 Each button SHALL pass a 2-flop synchronizer, then a debouncer updating its level only after DEB_CYCLES consecutive equal samples.
REQ-019 Debounced rising edge SHALL give one-cycle start_p / pause_p; holding a button SHALL give exactly one pulse.
REQ-020 Prescaler SHALL count 0..CLK_DIV-1 free-running, assert tick_1s when count = CLK_DIV-1, wrap to 0.
REQ-021 FSM states: IDLE=0, RUN=1, PAUSED=2, LIFE_LOST=3, OVER=4, WIN=5; codes 6-7 SHALL go to IDLE.
REQ-022 IDLE: start_p -> RUN; same edge latch timef<=mode_ext, lives<=LIVES.
REQ-023 RUN priority, highest first: time_left==0 -> OVER; goal -> WIN; collision -> (lives==1 ? OVER with lives 0 : LIFE_LOST with lives-1); pause_p -> PAUSED.
REQ-024 PAUSED: pause_p -> RUN; collision, goal, start_p ignored.
REQ-025 LIFE_LOST: hold counter cleared on entry, incremented per tick_1s; after HOLD_S ticks -> RUN; pause_p ignored.
REQ-026 OVER/WIN: start_p -> IDLE, clearing timef and lives to 0; all else ignored.
REQ-027 Outputs SHALL be registered from state: game_start=(state!=IDLE); game_on=(RUN); pause=(PAUSED or LIFE_LOST); endf=(OVER or WIN); win=(WIN).
REQ-028 timef SHALL remain constant from RUN entry until IDLE.
REQ-029 lives SHALL never underflow below 0 nor exceed LIVES.
REQ-030 time_left SHALL be examined only in RUN; zero in other states has no effect.

Reset
REQ-031 reset SHALL asynchronously force state=IDLE, lives=0, timef=0, outputs 0, prescaler/hold/debounce counters 0, debounced levels 0.
REQ-032 Reset mid-game SHALL abandon the game; first post-reset start_p SHALL begin a fresh game.
REQ-033 A button held through reset release SHALL produce no pulse until released and pressed again.

Structure
REQ-034 State encodings and default parameter values SHALL reside in shared package game_pkg.
REQ-035 Synchronizer+debouncer+edge detect SHALL be sub-module btn_conditioner, instantiated twice.
REQ-036 Prescaler and FSM SHALL be in game_sequencer; no gated or derived clocks.

Verification (CLK_DIV=10, DEB_CYCLES=4, LIVES=3, HOLD_S=2)
REQ-037 Press btn_start 8 cycles, mode_ext=1 -> one start_p, state RUN, game_start=1, timef=1, lives=3.
REQ-038 In RUN, 3-cycle glitch on btn_pause -> no change; 6-cycle press -> PAUSED, pause=1; second press -> RUN.
REQ-039 Collision in RUN -> LIFE_LOST, lives=2, pause=1; after 2 tick_1s -> RUN; third collision -> OVER, lives=0, endf=1.
REQ-040 Same cycle time_left=0 and goal -> OVER, win=0; separate game goal alone -> WIN, win=1, endf=1.
REQ-041 Reset asserted in PAUSED with btn_start held -> IDLE, all outputs 0, no start until release and re-press.
REQ-042 tick_1s period exactly 10 cycles across 5 periods, independent of state.
